anc_frame_sequencer: RTL and testbench

// Collects one sample from each enabled I2S receiver channel (e, x, a, u) into an aligned frame and hands it to anc_top over a valid/ready handshake.

---
 rtl/anc_pkg.sv | 24 ++
 rtl/anc_seq_slot.sv | 76 +++++++
 rtl/anc_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_anc_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/anc_pkg.sv
// -----------------------------------------------------------------------------
// anc_pkg
// Shared definitions for the ANC front-end frame sequencer: default sample
// width and channel count, the sequencer state encoding and the slot index of
// each I2S receiver channel within a frame.
// -----------------------------------------------------------------------------
package anc_pkg;

    localparam int ANC_SAMPLE_W = 16;
    localparam int ANC_NCH      = 4;

    // Slot index of each receiver channel inside ch_data / frame_data.
    localparam int CH_E = 0;   // error mic
    localparam int CH_X = 1;   // reference mic
    localparam int CH_A = 2;   // auxiliary
    localparam int CH_U = 3;   // user / playback

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        COLLECT   = 2'd1,
        ISSUE     = 2'd2
    } seq_state_t;

endpackage : anc_pkg

// File: rtl/anc_seq_slot.sv
// -----------------------------------------------------------------------------
// anc_seq_slot
// One channel slot of the frame sequencer. Holds the captured sample for the
// current frame and a "got" flag. When the frame times out without this slot
// being filled, the slot is substituted: with zero by default, or with the
// last sample captured on this channel when ANC_SEQ_HOLD_LAST_EN is defined.
//
// Configuration macro: ANC_SEQ_HOLD_LAST_EN (adds the last-value register).
//
// Ports
//   clk     in   1   core clock
//   rst_n   in   1   async active-low reset
//   clr_i   in   1   start a new frame: drop got flag and captured sample
//   cap_i   in   1   capture data_i into the slot (handshake on this channel)
//   fill_i  in   1   frame timed out with this slot empty: substitute
//   data_i  in   DW  incoming sample
//   got_o   out  1   slot holds a fresh sample for this frame
//   data_o  out  DW  slot contents as presented in the frame
// -----------------------------------------------------------------------------
module anc_seq_slot
    import anc_pkg::*;
#(
    parameter int DW = ANC_SAMPLE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 cap_i,
    input  logic                 fill_i,
    input  logic signed [DW-1:0] data_i,
    output logic                 got_o,
    output logic signed [DW-1:0] data_o
);

    logic                 got_q;
    logic signed [DW-1:0] cap_q;

`ifdef ANC_SEQ_HOLD_LAST_EN
    // Last sample ever captured on this channel; survives frame boundaries
    // and init_done aborts, only reset clears it.
    logic signed [DW-1:0] last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (cap_i && !clr_i) begin
            last_q <= data_i;
        end
    end
`endif

    // The capture register is cleared at every frame start, so a disabled
    // slot (never captured) naturally reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got_q <= 1'b0;
            cap_q <= '0;
        end else if (clr_i) begin
            got_q <= 1'b0;
            cap_q <= '0;
        end else if (cap_i) begin
            got_q <= 1'b1;
            cap_q <= data_i;
        end else if (fill_i) begin
`ifdef ANC_SEQ_HOLD_LAST_EN
            cap_q <= last_q;
`else
            cap_q <= '0;
`endif
        end
    end

    assign got_o  = got_q;
    assign data_o = cap_q;

endmodule : anc_seq_slot

// File: rtl/anc_frame_sequencer.sv
// -----------------------------------------------------------------------------
// anc_frame_sequencer
// Collects one sample from each enabled I2S receiver channel into an aligned
// frame and hands it to anc_top over valid/ready. Traffic is gated until
// init_done; a programmable skew timeout bounds how long a frame may wait for
// a dead channel, in which case missing slots are substituted and flagged.
//
// Configuration macro: ANC_SEQ_HOLD_LAST_EN -- timed-out slots repeat the
// channel's last captured sample instead of reading zero (see anc_seq_slot).
//
// Ports
//   clk             in   1       core clock
//   rst_n           in   1       async active-low reset
//   init_done       in   1       configuration complete (level)
//   ch_en           in   NCH     channel enable mask, latched at frame start
//   timeout_cycles  in   TO_W    skew limit in cycles, 0 disables the timeout
//   ch_vld          in   NCH     per-channel sample valid
//   ch_data         in   NCH*DW  channel i at [i*DW +: DW]
//   ch_rdy          out  NCH     per-channel ready
//   frame_vld       out  1       frame valid to anc_top
//   frame_rdy       in   1       anc_top ready
//   frame_data      out  NCH*DW  aligned frame, same slot order as ch_data
//   frame_stale     out  NCH     slot i was substituted (timed out)
//   timeout_cnt     out  CNT_W   saturating count of timed-out frames
//   stall_cnt       out  CNT_W   saturating count of back-pressured cycles
// -----------------------------------------------------------------------------
module anc_frame_sequencer
    import anc_pkg::*;
#(
    parameter int NCH   = ANC_NCH,
    parameter int DW    = ANC_SAMPLE_W,
    parameter int TO_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic [NCH-1:0]    ch_en,
    input  logic [TO_W-1:0]   timeout_cycles,
    input  logic [NCH-1:0]    ch_vld,
    input  logic [NCH*DW-1:0] ch_data,
    output logic [NCH-1:0]    ch_rdy,
    output logic              frame_vld,
    input  logic              frame_rdy,
    output logic [NCH*DW-1:0] frame_data,
    output logic [NCH-1:0]    frame_stale,
    output logic [CNT_W-1:0]  timeout_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    seq_state_t       state_q;
    logic [NCH-1:0]   en_q;
    logic [NCH-1:0]   stale_q;
    logic [TO_W-1:0]  timer_q;
    logic [CNT_W-1:0] timeout_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             frame_vld_q;

    logic [NCH-1:0]   got_w;
    logic [NCH-1:0]   ch_rdy_w;
    logic [NCH-1:0]   cap_w;
    logic [NCH-1:0]   got_d;
    logic [NCH-1:0]   fill_w;
    logic             started_w;
    logic             complete_w;
    logic             timeout_w;
    logic             abort_w;
    logic             handshake_w;
    logic             slot_clr_w;

    // ch_rdy depends only on registered state, never on ch_vld. got_d folds
    // in this cycle's captures so the last capture issues the frame on the
    // very next cycle.
    always_comb begin
        ch_rdy_w    = (state_q == COLLECT) ? (en_q & ~got_w) : '0;
        cap_w       = ch_vld & ch_rdy_w;
        got_d       = got_w | cap_w;
        started_w   = (|got_w) | (|cap_w);
        complete_w  = (state_q == COLLECT) && (en_q != '0) && (&(got_d | ~en_q));
        // The timer sits at 0 until the first capture and counts from there,
        // so during the first-capture cycle it already reads 0.
        timeout_w   = (state_q == COLLECT) && started_w && !complete_w &&
                      (timeout_cycles != '0) && (timer_q == timeout_cycles);
        abort_w     = !init_done && (state_q != WAIT_INIT);
        handshake_w = (state_q == ISSUE) && init_done && frame_rdy;
        slot_clr_w  = abort_w | handshake_w;
        fill_w      = (timeout_w && !abort_w) ? (en_q & ~got_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= WAIT_INIT;
            en_q          <= '0;
            stale_q       <= '0;
            timer_q       <= '0;
            timeout_cnt_q <= '0;
            stall_cnt_q   <= '0;
            frame_vld_q   <= 1'b0;
        end else begin
            if (frame_vld_q && !frame_rdy) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end

            case (state_q)
                WAIT_INIT: begin
                    if (init_done) begin
                        en_q    <= ch_en;
                        state_q <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (abort_w) begin
                        state_q <= WAIT_INIT;
                        timer_q <= '0;
                    end else if (complete_w) begin
                        state_q     <= ISSUE;
                        frame_vld_q <= 1'b1;
                        stale_q     <= '0;
                    end else if (timeout_w) begin
                        state_q       <= ISSUE;
                        frame_vld_q   <= 1'b1;
                        stale_q       <= en_q & ~got_d;
                        timeout_cnt_q <= sat_inc(timeout_cnt_q);
                    end else if (started_w) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ISSUE: begin
                    if (abort_w) begin
                        state_q     <= WAIT_INIT;
                        frame_vld_q <= 1'b0;
                        stale_q     <= '0;
                        timer_q     <= '0;
                    end else if (handshake_w) begin
                        state_q     <= COLLECT;
                        frame_vld_q <= 1'b0;
                        stale_q     <= '0;
                        timer_q     <= '0;
                        en_q        <= ch_en;
                    end
                end

                default: begin
                    state_q     <= WAIT_INIT;
                    frame_vld_q <= 1'b0;
                end
            endcase
        end
    end

    // The slot capture registers double as the frame output: nothing is
    // captured while in ISSUE, so frame_data is stable for the whole offer.
    for (genvar i = 0; i < NCH; i++) begin : g_slot
        anc_seq_slot #(
            .DW(DW)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (slot_clr_w),
            .cap_i  (cap_w[i]),
            .fill_i (fill_w[i]),
            .data_i (ch_data[i*DW +: DW]),
            .got_o  (got_w[i]),
            .data_o (frame_data[i*DW +: DW])
        );
    end

    assign ch_rdy      = ch_rdy_w;
    assign frame_vld   = frame_vld_q;
    assign frame_stale = stale_q;
    assign timeout_cnt = timeout_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule : anc_frame_sequencer

// File: tb/tb_anc_frame_sequencer.sv
module tb_anc_frame_sequencer;
    import anc_pkg::*;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int TO_W  = 16;
    localparam int CNT_W = 4;

`ifdef ANC_SEQ_HOLD_LAST_EN
    localparam logic [15:0] T2_SLOT3 = 16'h4444;
`else
    localparam logic [15:0] T2_SLOT3 = 16'h0000;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_done;
    logic [NCH-1:0]    ch_en;
    logic [TO_W-1:0]   timeout_cycles;
    logic [NCH-1:0]    ch_vld;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_rdy;
    logic              frame_vld;
    logic              frame_rdy;
    logic [NCH*DW-1:0] frame_data;
    logic [NCH-1:0]    frame_stale;
    logic [CNT_W-1:0]  timeout_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [CNT_W-1:0] exp_to;

    always #5 clk = ~clk;

    anc_frame_sequencer #(
        .NCH(NCH), .DW(DW), .TO_W(TO_W), .CNT_W(CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .init_done      (init_done),
        .ch_en          (ch_en),
        .timeout_cycles (timeout_cycles),
        .ch_vld         (ch_vld),
        .ch_data        (ch_data),
        .ch_rdy         (ch_rdy),
        .frame_vld      (frame_vld),
        .frame_rdy      (frame_rdy),
        .frame_data     (frame_data),
        .frame_stale    (frame_stale),
        .timeout_cnt    (timeout_cnt),
        .stall_cnt      (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        init_done      = 1'b0;
        ch_en          = 4'b1111;
        ch_vld         = '0;
        ch_data        = '0;
        timeout_cycles = '0;
        frame_rdy      = 1'b1;
        exp_to         = '0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        check("rst_vld",   64'(frame_vld),   64'(1'b0));
        check("rst_rdy",   64'(ch_rdy),      64'(4'b0000));
        check("rst_data",  64'(frame_data),  64'h0);
        check("rst_stale", 64'(frame_stale), 64'(4'b0000));
        check("rst_tocnt", 64'(timeout_cnt), 64'(4'h0));
        check("rst_stall", 64'(stall_cnt),   64'(4'h0));
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("wait_init_rdy", 64'(ch_rdy), 64'(4'b0000));
        step();
        init_done = 1'b1;
        step();

        // 1: complete frame, channels arrive at cycles 3,5,7,9
        ch_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int c = 0; c <= 10; c++) begin
            ch_vld = (c == 3) ? 4'b0001 : (c == 5) ? 4'b0010 :
                     (c == 7) ? 4'b0100 : (c == 9) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            if (c == 4) check("t1_rdy_c4", 64'(ch_rdy), 64'(4'b1110));
            if (c == 9) check("t1_vld_c9", 64'(frame_vld), 64'(1'b0));
            if (c == 10) begin
                check("t1_vld_c10", 64'(frame_vld),   64'(1'b1));
                check("t1_data",    64'(frame_data),  64'h4444_3333_2222_1111);
                check("t1_stale",   64'(frame_stale), 64'(4'b0000));
            end
            step();
        end
        ch_vld = '0;
        @(negedge clk);
        check("t1_vld_drop", 64'(frame_vld), 64'(1'b0));
        timeout_cycles = 16'd8;
        step();

        // 2: timeout, ch3 never arrives
        ch_data = {16'h9999, 16'hC2C2, 16'hB1B1, 16'hA0A0};
        for (int c = 0; c <= 9; c++) begin
            ch_vld = (c == 0) ? 4'b0001 : (c == 2) ? 4'b0010 :
                     (c == 4) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (c == 8) check("t2_vld_c8", 64'(frame_vld), 64'(1'b0));
            if (c == 9) begin
                exp_to = 4'd1;
                check("t2_vld_c9", 64'(frame_vld),   64'(1'b1));
                check("t2_stale",  64'(frame_stale), 64'(4'b1000));
                check("t2_data",   64'(frame_data),  {T2_SLOT3, 48'hC2C2_B1B1_A0A0});
                check("t2_tocnt",  64'(timeout_cnt), 64'(exp_to));
            end
            step();
        end
        ch_vld         = '0;
        timeout_cycles = '0;
        step();

        // 3: backpressure for 5 cycles, then back-to-back frame
        for (int c = 0; c <= 9; c++) begin
            frame_rdy = (c == 0) || (c >= 6);
            ch_vld    = (c == 9) ? 4'b0000 : 4'b1111;
            ch_data   = (c == 0) ? {16'h0404, 16'h0303, 16'h0202, 16'h0101}
                                 : {16'h1d1d, 16'h1c1c, 16'h1b1b, 16'h1a1a};
            if (c == 8) ch_en = 4'b0101;
            @(negedge clk);
            if (c >= 1 && c <= 5) begin
                check("t3_hold_vld",  64'(frame_vld),  64'(1'b1));
                check("t3_hold_data", 64'(frame_data), 64'h0404_0303_0202_0101);
                check("t3_hold_rdy",  64'(ch_rdy),     64'(4'b0000));
            end
            if (c == 6) begin
                check("t3_stall", 64'(stall_cnt), 64'(4'd5));
                check("t3_vld6",  64'(frame_vld), 64'(1'b1));
            end
            if (c == 7) begin
                check("t3_gap_vld", 64'(frame_vld), 64'(1'b0));
                check("t3_gap_rdy", 64'(ch_rdy),    64'(4'b1111));
            end
            if (c == 8) begin
                check("t3_b2b_vld",  64'(frame_vld),  64'(1'b1));
                check("t3_b2b_data", 64'(frame_data), 64'h1d1d_1c1c_1b1b_1a1a);
            end
            if (c == 9) check("t3_drop", 64'(frame_vld), 64'(1'b0));
            step();
        end

        // 4: mask 0101, channels 1 and 3 held valid
        ch_en = 4'b1111;
        ch_data[CH_E*DW +: DW] = 16'h1234;
        ch_data[CH_X*DW +: DW] = 16'h5678;
        ch_data[CH_A*DW +: DW] = 16'h9abc;
        ch_data[CH_U*DW +: DW] = 16'hdef0;
        for (int c = 0; c <= 5; c++) begin
            ch_vld         = '0;
            ch_vld[CH_X]   = 1'b1;
            ch_vld[CH_U]   = 1'b1;
            ch_vld[CH_E]   = (c == 2);
            ch_vld[CH_A]   = (c == 4);
            @(negedge clk);
            if (c == 0) check("t4_rdy_c0", 64'(ch_rdy), 64'(4'b0101));
            if (c == 3) check("t4_rdy_c3", 64'(ch_rdy), 64'(4'b0100));
            if (c == 4) check("t4_vld_c4", 64'(frame_vld), 64'(1'b0));
            if (c == 5) begin
                check("t4_vld_c5", 64'(frame_vld),   64'(1'b1));
                check("t4_data",   64'(frame_data),  64'h0000_9abc_0000_1234);
                check("t4_stale",  64'(frame_stale), 64'(4'b0000));
            end
            step();
        end
        ch_vld = '0;

        // 5: async reset with two channels captured
        for (int c = 0; c <= 2; c++) begin
            ch_vld  = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
            ch_data = {16'h0000, 16'h0000, 16'hBBBB, 16'hAAAA};
            @(negedge clk);
            if (c == 2) check("t5_rdy_partial", 64'(ch_rdy), 64'(4'b1100));
            step();
        end
        rst_n     = 1'b0;
        init_done = 1'b0;
        exp_to    = '0;
        @(negedge clk);
        check("t5_rst_vld",   64'(frame_vld),   64'(1'b0));
        check("t5_rst_data",  64'(frame_data),  64'h0);
        check("t5_rst_stale", 64'(frame_stale), 64'(4'b0000));
        check("t5_rst_rdy",   64'(ch_rdy),      64'(4'b0000));
        check("t5_rst_tocnt", 64'(timeout_cnt), 64'(4'h0));
        check("t5_rst_stall", 64'(stall_cnt),   64'(4'h0));
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("t5_wait_vld", 64'(frame_vld), 64'(1'b0));
        init_done = 1'b1;
        step();
        ch_data = {16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC};
        for (int c = 0; c <= 2; c++) begin
            ch_vld = (c == 0) ? 4'b0011 : (c == 1) ? 4'b1100 : 4'b0000;
            @(negedge clk);
            if (c < 2) check("t5_no_partial", 64'(frame_vld), 64'(1'b0));
            if (c == 2) begin
                check("t5_fresh_vld",  64'(frame_vld),  64'(1'b1));
                check("t5_fresh_data", 64'(frame_data), 64'hFFFF_EEEE_DDDD_CCCC);
            end
            step();
        end
        ch_vld         = '0;
        timeout_cycles = 16'd1;
        step();

        // 6: counter saturation over 20 timed-out frames
        for (int f = 0; f < 20; f++) begin
            ch_vld  = 4'b0001;
            ch_data = {48'h0, 16'(f + 16'h100)};
            step();
            ch_vld = '0;
            step();
            @(negedge clk);
            exp_to = (&exp_to) ? exp_to : exp_to + 1'b1;
            check("t6_tocnt", 64'(timeout_cnt), 64'(exp_to));
            if (f == 0) begin
                check("t6_vld",   64'(frame_vld),          64'(1'b1));
                check("t6_stale", 64'(frame_stale),        64'(4'b1110));
                check("t6_slot0", 64'(frame_data[15:0]),   64'(16'h0100));
            end
            step();
        end
        repeat (3) step();
        @(negedge clk);
        check("t6_sat_hold", 64'(timeout_cnt), 64'(4'hF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_anc_frame_sequencer
